// File: rtl/eth_hdr_pkg.sv
// Shared Ethernet/IPv4/ARP/L4 header layout for the reply-header datapath.
// Byte offsets count from the first byte on the wire, which sits in the top byte of the header bus.
package eth_hdr_pkg;

  localparam int HEAD_BYTES = 42;
  localparam int HEAD_W     = HEAD_BYTES * 8;

  typedef enum logic [1:0] {
    PROTO_NONE = 2'd0,
    PROTO_ARP  = 2'd1,
    PROTO_ICMP = 2'd2,
    PROTO_UDP  = 2'd3
  } proto_e;

  localparam int ETH_DST_OFF  = 0;
  localparam int ETH_SRC_OFF  = 6;
  localparam int ETH_TYPE_OFF = 12;

  localparam int IP_OFF      = 14;
  localparam int IP_WORDS    = 10;
  localparam int IP_TTL_OFF  = 22;
  localparam int IP_CSUM_OFF = 24;
  localparam int IP_SRC_OFF  = 26;
  localparam int IP_DST_OFF  = 30;

  localparam int ARP_OPER_OFF = 20;
  localparam int ARP_SHA_OFF  = 22;
  localparam int ARP_SPA_OFF  = 28;
  localparam int ARP_THA_OFF  = 32;
  localparam int ARP_TPA_OFF  = 38;

  localparam int UDP_SPORT_OFF = 34;
  localparam int UDP_DPORT_OFF = 36;
  localparam int UDP_LEN_OFF   = 38;
  localparam int UDP_CSUM_OFF  = 40;

  localparam int ICMP_TYPE_OFF = 34;
  localparam int ICMP_CODE_OFF = 35;
  localparam int ICMP_CSUM_OFF = 36;

  localparam logic [15:0] OPER_REPLY           = 16'h0002;
  localparam logic [7:0]  ICMP_TYPE_ECHO_REPLY = 8'h00;
  // Echo request (type 8) -> reply (type 0) changes the type/code word by 0x0800.
  localparam logic [15:0] ICMP_ECHO_CSUM_DELTA = 16'h0800;

  // Bus bit index of the most significant bit of the byte at offset off.
  function automatic int hi(input int off);
    return HEAD_W - 1 - 8 * off;
  endfunction

  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/eth_csum16_acc.sv
// Serial ones-complement checksum accumulator: clear, add one 16-bit word per cycle, fold to a 16-bit checksum.
// Twenty bits of headroom let up to sixteen full-scale words accumulate before folding.
module eth_csum16_acc (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_add,
  input  logic [15:0] i_word,
  output logic [15:0] o_csum
);

  logic [19:0] acc_q;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      acc_q <= '0;
    end else if (i_add) begin
      acc_q <= acc_q + {4'd0, i_word};
    end
  end

  // The second fold cannot carry: a first-fold carry leaves at most 0x000E in the low half.
  always_comb begin
    fold1  = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    fold2  = fold1[15:0] + {15'd0, fold1[16]};
    o_csum = ~fold2;
  end

endmodule

// File: rtl/ethernet_reply_head_engine.sv
// Builds ARP, ICMP-echo and UDP reply headers from a received 42-byte header,
// then fills in the IPv4 header checksum serially before presenting the reply.
module ethernet_reply_head_engine
  import eth_hdr_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC     = 48'h211abcdef112,
  parameter logic [31:0] FPGA_IP      = 32'hC0000186,
  parameter logic [15:0] UDP_PORT_DST = 16'h0000,
  parameter logic [7:0]  REPLY_TTL    = 8'h40
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_head_valid,
  output logic              o_head_ready,
  input  logic [HEAD_W-1:0] i_head,
  input  logic [1:0]        i_proto,
  output logic              o_reply_valid,
  input  logic              i_reply_ready,
  output logic [HEAD_W-1:0] o_reply_head,
  output logic [1:0]        o_reply_proto,
  output logic [15:0]       o_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CSUM,
    S_FOLD,
    S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [HEAD_W-1:0] head_q, load_head;
  proto_e            proto_q;
  logic [3:0]        word_idx_q;
  logic [15:0]       drop_cnt_q;
  logic [15:0]       csum_word;
  logic [15:0]       ip_csum;
  logic              accept;

  assign accept        = i_head_valid && (state_q == S_IDLE);
  assign o_head_ready  = (state_q == S_IDLE);
  assign o_reply_valid = (state_q == S_OUT);
  assign o_reply_head  = head_q;
  assign o_reply_proto = proto_q;
  assign o_drop_cnt    = drop_cnt_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && proto_e'(i_proto) != PROTO_NONE) state_d = S_LOAD;
      S_LOAD: state_d = (proto_q == PROTO_ARP) ? S_OUT : S_CSUM;
      S_CSUM: if (word_idx_q == 4'(IP_WORDS - 1)) state_d = S_FOLD;
      S_FOLD: state_d = S_OUT;
      S_OUT:  if (i_reply_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Field rewrites applied to the captured request in the single LOAD cycle.
  always_comb begin
    load_head = head_q;
    load_head[hi(ETH_DST_OFF) -: 48] = head_q[hi(ETH_SRC_OFF) -: 48];
    load_head[hi(ETH_SRC_OFF) -: 48] = FPGA_MAC;
    if (proto_q == PROTO_ARP) begin
      load_head[hi(ARP_OPER_OFF) -: 16] = OPER_REPLY;
      load_head[hi(ARP_SHA_OFF)  -: 48] = FPGA_MAC;
      load_head[hi(ARP_SPA_OFF)  -: 32] = FPGA_IP;
      load_head[hi(ARP_THA_OFF)  -: 48] = head_q[hi(ARP_SHA_OFF) -: 48];
      load_head[hi(ARP_TPA_OFF)  -: 32] = head_q[hi(ARP_SPA_OFF) -: 32];
    end else begin
      load_head[hi(IP_TTL_OFF)  -: 8]  = REPLY_TTL;
      load_head[hi(IP_CSUM_OFF) -: 16] = 16'h0000;
      load_head[hi(IP_SRC_OFF)  -: 32] = head_q[hi(IP_DST_OFF) -: 32];
      load_head[hi(IP_DST_OFF)  -: 32] = head_q[hi(IP_SRC_OFF) -: 32];
      if (proto_q == PROTO_ICMP) begin
        load_head[hi(ICMP_TYPE_OFF) -: 8]  = ICMP_TYPE_ECHO_REPLY;
        load_head[hi(ICMP_CSUM_OFF) -: 16] =
          ones_add16(head_q[hi(ICMP_CSUM_OFF) -: 16], ICMP_ECHO_CSUM_DELTA);
      end else begin
        load_head[hi(UDP_SPORT_OFF) -: 16] = head_q[hi(UDP_DPORT_OFF) -: 16];
        load_head[hi(UDP_DPORT_OFF) -: 16] = UDP_PORT_DST;
        load_head[hi(UDP_CSUM_OFF)  -: 16] = 16'h0000;
      end
    end
  end

  always_comb begin
    csum_word = '0;
    for (int i = 0; i < IP_WORDS; i++) begin
      if (word_idx_q == 4'(i)) csum_word = head_q[hi(IP_OFF) - 16 * i -: 16];
    end
  end

  eth_csum16_acc u_csum (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (state_q == S_LOAD),
    .i_add   (state_q == S_CSUM),
    .i_word  (csum_word),
    .o_csum  (ip_csum)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the header register is reset too, because it drives o_reply_head directly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      proto_q    <= PROTO_NONE;
      word_idx_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (proto_e'(i_proto) == PROTO_NONE) begin
              if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end else begin
              head_q  <= i_head;
              proto_q <= proto_e'(i_proto);
            end
          end
        end
        S_LOAD: begin
          head_q     <= load_head;
          word_idx_q <= '0;
        end
        S_CSUM: word_idx_q <= word_idx_q + 4'd1;
        S_FOLD: head_q[hi(IP_CSUM_OFF) -: 16] <= ip_csum;
        default: ;
      endcase
    end
  end

endmodule
